// File: rtl/cpu_seq.sv
// Instruction sequencer for the 4-bit CPU: PC, instruction register, decode into
// datapath strobes, JMP/JNC resolution against the carry flag, run/step/halt control.
module cpu_seq #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              run,
  input  logic              step,
  input  logic              halt_req,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              carry_in,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [3:0]        opcode,
  output logic [3:0]        imm,
  output logic [1:0]        src_sel,
  output logic              ld_a,
  output logic              ld_b,
  output logic              ld_out,
  output logic              c_flag,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  typedef enum logic [1:0] {SRC_A = 2'd0, SRC_B = 2'd1, SRC_IN = 2'd2, SRC_ZERO = 2'd3} src_t;

  typedef enum logic [3:0] {
    OP_ADD_A_IM = 4'b0000, OP_MOV_A_B  = 4'b0001, OP_IN_A     = 4'b0010, OP_MOV_A_IM = 4'b0011,
    OP_MOV_B_A  = 4'b0100, OP_ADD_B_IM = 4'b0101, OP_IN_B     = 4'b0110, OP_MOV_B_IM = 4'b0111,
    OP_OUT_B    = 4'b1001, OP_OUT_IM   = 4'b1011, OP_JNC      = 4'b1110, OP_JMP      = 4'b1111
  } op_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   ir;

  logic [3:0]          ir_op;
  logic [ADDR_W-1:0]   imm_ext;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   next_pc;
  logic                self_jump;

  src_t                dec_src;
  logic                dec_ld_a, dec_ld_b, dec_ld_out;
  logic                dec_set_c;
  logic                dec_illegal;

  assign ir_op   = ir[DATA_W-1 -: 4];
  assign imm_ext = ADDR_W'(ir[3:0]);
  assign pc_inc  = pc + ADDR_W'(1);

  // Instruction decode: ALU source, destination strobe, carry update, legality.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    dec_src     = SRC_A;
    dec_ld_a    = 1'b0;
    dec_ld_b    = 1'b0;
    dec_ld_out  = 1'b0;
    dec_set_c   = 1'b0;
    dec_illegal = 1'b0;
    case (ir_op)
      OP_ADD_A_IM: begin dec_src = SRC_A;    dec_ld_a   = 1'b1; dec_set_c = 1'b1; end
      OP_MOV_A_B:  begin dec_src = SRC_B;    dec_ld_a   = 1'b1; dec_set_c = 1'b1; end
      OP_IN_A:     begin dec_src = SRC_IN;   dec_ld_a   = 1'b1; dec_set_c = 1'b1; end
      OP_MOV_A_IM: begin dec_src = SRC_ZERO; dec_ld_a   = 1'b1; dec_set_c = 1'b1; end
      OP_MOV_B_A:  begin dec_src = SRC_A;    dec_ld_b   = 1'b1; dec_set_c = 1'b1; end
      OP_ADD_B_IM: begin dec_src = SRC_B;    dec_ld_b   = 1'b1; dec_set_c = 1'b1; end
      OP_IN_B:     begin dec_src = SRC_IN;   dec_ld_b   = 1'b1; dec_set_c = 1'b1; end
      OP_MOV_B_IM: begin dec_src = SRC_ZERO; dec_ld_b   = 1'b1; dec_set_c = 1'b1; end
      OP_OUT_B:    begin dec_src = SRC_B;    dec_ld_out = 1'b1; end
      OP_OUT_IM:   begin dec_src = SRC_ZERO; dec_ld_out = 1'b1; end
      OP_JNC, OP_JMP: ;
      default:     dec_illegal = 1'b1;
    endcase
  end

  // Branch resolution; JNC looks at the carry left by the previous instruction.
  always_comb begin
    next_pc   = pc_inc;
    self_jump = 1'b0;
    if (ir_op == OP_JMP) begin
      next_pc   = imm_ext;
      self_jump = (imm_ext == pc);
    end else if (ir_op == OP_JNC && !c_flag) begin
      next_pc   = imm_ext;
      self_jump = (imm_ext == pc);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if ((run || step) && !halt_req) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC: begin
        if (self_jump)             state_nxt = S_HALT;
        else if (halt_req || !run) state_nxt = S_IDLE;
        else                       state_nxt = S_FETCH;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: strobes are gated by EXEC so an async reset drops them at once.
  always_comb begin
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_out  = 1'b0;
    src_sel = SRC_A;
    if (state == S_EXEC) begin
      ld_a    = dec_ld_a;
      ld_b    = dec_ld_b;
      ld_out  = dec_ld_out;
      src_sel = dec_src;
    end
  end

  assign halted   = (state == S_HALT);
  assign rom_addr = pc;
  assign opcode   = ir_op;
  assign imm      = ir[3:0];

  // Architectural registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc      <= '0;
      ir      <= '0;
      c_flag  <= 1'b0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (state == S_FETCH) ir <= rom_data;
      if (state == S_EXEC) begin
        c_flag  <= dec_set_c ? carry_in : 1'b0;
        pc      <= next_pc;
        illegal <= illegal | dec_illegal;
        if (retired != {CNT_W{1'b1}}) retired <= retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_seq.sv
// Directed bench for cpu_seq: ROM model, scoreboard of expected per-instruction
// strobes and post-instruction PC/carry/retired values.
module tb_cpu_seq;

  logic       clk, rstn, run, step, halt_req, carry_in;
  logic [7:0] rom_data;
  logic [3:0] rom_addr, opcode, imm;
  logic [1:0] src_sel;
  logic       ld_a, ld_b, ld_out, c_flag, halted, illegal;
  logic [7:0] retired;

  logic [7:0] rom [16];
  assign rom_data = rom[rom_addr];

  cpu_seq dut (
    .clk(clk), .rstn(rstn), .run(run), .step(step), .halt_req(halt_req),
    .rom_data(rom_data), .carry_in(carry_in), .rom_addr(rom_addr),
    .opcode(opcode), .imm(imm), .src_sel(src_sel), .ld_a(ld_a), .ld_b(ld_b),
    .ld_out(ld_out), .c_flag(c_flag), .halted(halted), .illegal(illegal),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [3:0] im;
    logic       has_src;
    logic [1:0] src;
    logic [2:0] ld;     // {ld_a, ld_b, ld_out}
    logic [3:0] npc;
    logic       c;
    logic [7:0] ret;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push the expectation, then check it during EXEC (next negedge) and after the ending edge.
  task automatic do_instr(input string tag, input logic [7:0] instr, input logic has_src,
                          input logic [1:0] src, input logic [2:0] ld, input logic [3:0] npc,
                          input logic c, input logic [7:0] ret, input logic cin);
    exp_t e;
    e.op = instr[7:4]; e.im = instr[3:0]; e.has_src = has_src; e.src = src;
    e.ld = ld; e.npc = npc; e.c = c; e.ret = ret;
    carry_in = cin;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, ".opcode"}, opcode, e.op);
    chk({tag, ".imm"}, imm, e.im);
    if (e.has_src) chk({tag, ".src_sel"}, src_sel, e.src);
    chk({tag, ".ld"}, {ld_a, ld_b, ld_out}, e.ld);
    @(negedge clk);
    chk({tag, ".pc"}, rom_addr, e.npc);
    chk({tag, ".c_flag"}, c_flag, e.c);
    chk({tag, ".retired"}, retired, e.ret);
  endtask

  task automatic quiet(input string tag, input logic [3:0] pc, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, ".ld"}, {ld_a, ld_b, ld_out}, 3'b000);
      chk({tag, ".pc"}, rom_addr, pc);
    end
  endtask

  task automatic step_pulse();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0]  = 8'h35; rom[1]  = 8'h01; rom[2]  = 8'hE7; rom[3]  = 8'h01;
    rom[4]  = 8'hE7; rom[7]  = 8'h47; rom[8]  = 8'h90; rom[9]  = 8'h60;
    rom[10] = 8'h53; rom[11] = 8'hBA; rom[12] = 8'hFF; rom[15] = 8'hFF;
    run = 1'b1; step = 1'b0; halt_req = 1'b0; carry_in = 1'b0; rstn = 1'b0;

    // Reset state, held with run=1 and the clock toggling
    repeat (2) @(negedge clk);
    chk("rst.pc", rom_addr, 4'd0);
    chk("rst.ir", {opcode, imm}, 8'h00);
    chk("rst.ld", {ld_a, ld_b, ld_out}, 3'b000);
    chk("rst.src_sel", src_sel, 2'd0);
    chk("rst.c_flag", c_flag, 1'b0);
    chk("rst.halted", halted, 1'b0);
    chk("rst.illegal", illegal, 1'b0);
    chk("rst.retired", retired, 8'd0);
    rstn = 1'b1;

    // Free-run: MOV/ADD and both JNC outcomes
    @(negedge clk);
    chk("fetch0.ld", {ld_a, ld_b, ld_out}, 3'b000);
    do_instr("mov_a_im", 8'h35, 1, 2'd3, 3'b100, 4'd1, 1'b0, 8'd1, 1'b0);
    do_instr("add_a_c1", 8'h01, 1, 2'd0, 3'b100, 4'd2, 1'b1, 8'd2, 1'b1);
    do_instr("jnc_nt",   8'hE7, 0, 2'd0, 3'b000, 4'd3, 1'b0, 8'd3, 1'b0);
    do_instr("add_a_c0", 8'h01, 1, 2'd0, 3'b100, 4'd4, 1'b0, 8'd4, 1'b0);
    do_instr("jnc_t",    8'hE7, 0, 2'd0, 3'b000, 4'd7, 1'b0, 8'd5, 1'b1);

    // Drop run: finish this instruction, then sit in IDLE
    run = 1'b0;
    do_instr("mov_b_a",  8'h47, 1, 2'd0, 3'b010, 4'd8, 1'b1, 8'd6, 1'b1);
    quiet("idle1", 4'd8, 3);

    // Single-step
    step_pulse();
    chk("step1.fetch.ld", {ld_a, ld_b, ld_out}, 3'b000);
    do_instr("out_b",    8'h90, 1, 2'd1, 3'b001, 4'd9, 1'b0, 8'd7, 1'b1);
    quiet("idle2", 4'd9, 2);
    step_pulse();
    do_instr("in_b",     8'h60, 1, 2'd2, 3'b010, 4'd10, 1'b1, 8'd8, 1'b1);
    quiet("idle3", 4'd10, 1);

    // halt_req blocks leaving IDLE even with run=1
    run = 1'b1; halt_req = 1'b1;
    quiet("hold", 4'd10, 3);
    halt_req = 1'b0;
    @(negedge clk);
    chk("resume.fetch.ld", {ld_a, ld_b, ld_out}, 3'b000);
    do_instr("add_b",    8'h53, 1, 2'd1, 3'b010, 4'd11, 1'b0, 8'd9, 1'b0);
    do_instr("out_im",   8'hBA, 1, 2'd3, 3'b001, 4'd12, 1'b0, 8'd10, 1'b1);
    do_instr("jmp15",    8'hFF, 0, 2'd0, 3'b000, 4'd15, 1'b0, 8'd11, 1'b0);
    do_instr("self_jmp", 8'hFF, 0, 2'd0, 3'b000, 4'd15, 1'b0, 8'd12, 1'b0);
    chk("halt.halted", halted, 1'b1);

    // HALT ignores run and step
    step_pulse();
    repeat (3) @(negedge clk);
    chk("halt.hold.halted", halted, 1'b1);
    chk("halt.hold.pc", rom_addr, 4'd15);
    chk("halt.hold.retired", retired, 8'd12);
    chk("halt.hold.ld", {ld_a, ld_b, ld_out}, 3'b000);

    // Reset leaves HALT asynchronously
    rstn = 1'b0; run = 1'b0;
    #1;
    chk("rst2.halted", halted, 1'b0);
    chk("rst2.pc", rom_addr, 4'd0);
    chk("rst2.retired", retired, 8'd0);

    // Illegal opcode at pc=15 with carry set beforehand
    rom[0] = 8'hFE; rom[14] = 8'h21; rom[15] = 8'h80;
    @(negedge clk);
    rstn = 1'b1; run = 1'b1;
    @(negedge clk);
    do_instr("jmp14",    8'hFE, 0, 2'd0, 3'b000, 4'd14, 1'b0, 8'd1, 1'b1);
    do_instr("in_a",     8'h21, 1, 2'd2, 3'b100, 4'd15, 1'b1, 8'd2, 1'b1);
    chk("pre_ill.illegal", illegal, 1'b0);
    do_instr("illegal",  8'h80, 0, 2'd0, 3'b000, 4'd0, 1'b0, 8'd3, 1'b1);
    chk("ill.illegal", illegal, 1'b1);
    run = 1'b0;
    do_instr("jmp14b",   8'hFE, 0, 2'd0, 3'b000, 4'd14, 1'b0, 8'd4, 1'b1);
    chk("ill.sticky", illegal, 1'b1);

    // Reset in the middle of EXEC of OUT Im
    rstn = 1'b0;
    rom[0] = 8'h35; rom[1] = 8'hB7;
    @(negedge clk);
    rstn = 1'b1; run = 1'b1;
    @(negedge clk);
    do_instr("mov_a_im2", 8'h35, 1, 2'd3, 3'b100, 4'd1, 1'b0, 8'd1, 1'b0);
    @(negedge clk);
    chk("abort.pre.ld", {ld_a, ld_b, ld_out}, 3'b001);
    chk("abort.pre.src_sel", src_sel, 2'd3);
    chk("abort.pre.imm", imm, 4'd7);
    #2 rstn = 1'b0;
    #1;
    chk("abort.ld", {ld_a, ld_b, ld_out}, 3'b000);
    chk("abort.pc", rom_addr, 4'd0);
    chk("abort.retired", retired, 8'd0);
    chk("sb.empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
